// File: rtl/wiener_calc_mc.sv
// Wiener filter block for multi-channel pixels.
// Latches per-channel block statistics, derives one fixed-point gain per
// channel, then streams TOTAL_SAMPLES pixels through a 2-stage pipeline:
//   out = clamp(mean + ((gain * (x - mean)) >>> GAIN_FRAC), 0, 2^W-1)
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   stats_ready             one-cycle pulse, statistics inputs are valid
//   mean_of_block           per-channel mean, channel c at [c*2W +: 2W]
//   variance_of_block       per-channel variance, same layout
//   noise_variance          noise variance shared by all channels
//   blocks_per_frame        blocks per frame (0 is treated as 1)
//   data_in/_valid/_ready   pixel input handshake (ready only while streaming)
//   data_out/_valid         filtered pixel, valid 2 cycles after acceptance
//   data_count_out          pixels accepted in the current block
//   block_done, frame_done  pulses aligned with the block's/frame's last output
//   stats_overrun           pulse when stats_ready was dropped while busy
module wiener_calc_mc #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TOTAL_SAMPLES = 64,
  parameter int unsigned NUM_CHANNELS  = 3,
  parameter int unsigned GAIN_FRAC     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stats_ready,
  input  logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] mean_of_block,
  input  logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] variance_of_block,
  input  logic [2*DATA_WIDTH-1:0]             noise_variance,
  input  logic [31:0]                         blocks_per_frame,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_out,
  output logic                                data_out_valid,
  output logic [31:0]                         data_count_out,
  output logic                                block_done,
  output logic                                frame_done,
  output logic                                stats_overrun
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned C  = NUM_CHANNELS;
  localparam int unsigned GF = GAIN_FRAC;
  localparam int unsigned SW = 2 * W;          // statistics width
  localparam int unsigned NW = SW + GF;        // divider numerator width
  localparam int unsigned GW = GF + 1;         // gain < 2^GF always fits
  localparam int unsigned PW = 2 * W + GF + 2; // signed product width

  typedef enum logic [1:0] {IDLE, GAIN, STREAM} state_t;

  state_t                state_q;
  logic                  ready_q;
  logic [W-1:0]          mean_q  [C];
  logic [SW-1:0]         var_q   [C];
  logic [SW-1:0]         noise_q;
  logic [GW-1:0]         gain_q  [C];
  logic [31:0]           count_q;
  logic [31:0]           blk_q;
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic signed [PW-1:0]  s1_sum_q [C];
  logic [C*W-1:0]        out_q;
  logic                  out_valid_q;
  logic                  block_done_q;
  logic                  frame_done_q;
  logic                  overrun_q;

  logic                  accept;
  logic                  last_accept;
  logic                  latch_stats;
  logic                  frame_hit;
  logic [31:0]           bpf_eff;
  logic [W-1:0]          mean_sat [C];
  logic [GW-1:0]         gain_d   [C];
  logic signed [PW-1:0]  sum_d    [C];
  logic [C*W-1:0]        out_d;

  assign accept      = data_in_valid && ready_q;
  assign last_accept = accept && (count_q == 32'(TOTAL_SAMPLES - 1));
  // A stats pulse is taken in IDLE, or on the block's last pixel so the next
  // block can start without passing through IDLE.
  assign latch_stats = stats_ready &&
                       ((state_q == IDLE) || ((state_q == STREAM) && last_accept));
  assign bpf_eff     = (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
  assign frame_hit   = (blk_q + 32'd1) >= bpf_eff;

  always_comb begin
    for (int unsigned c = 0; c < C; c++) begin
      mean_sat[c] = (|mean_of_block[c*SW+W +: W]) ? '1 : mean_of_block[c*SW +: W];
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < C; c++) begin
      gain_d[c] = '0;
      if (var_q[c] > noise_q) begin
        gain_d[c] = GW'((NW'(var_q[c] - noise_q) << GF) / NW'(var_q[c]));
      end
    end
  end

  // Stage 1 datapath: signed difference, gain product, floor shift, add mean.
  always_comb begin
    logic signed [W:0]    d;
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;
    for (int unsigned c = 0; c < C; c++) begin
      d        = $signed({1'b0, data_in[c*W +: W]}) - $signed({1'b0, mean_q[c]});
      d_ext    = {{(PW-W-1){d[W]}}, d};
      g_ext    = $signed({{(PW-GW){1'b0}}, gain_q[c]});
      prod     = g_ext * d_ext;
      sum_d[c] = (prod >>> GF) + $signed({{(PW-W){1'b0}}, mean_q[c]});
    end
  end

  // Stage 2 datapath: clamp to the pixel range.
  always_comb begin
    out_d = '0;
    for (int unsigned c = 0; c < C; c++) begin
      if (s1_sum_q[c][PW-1]) begin
        out_d[c*W +: W] = '0;
      end else if (|s1_sum_q[c][PW-2:W]) begin
        out_d[c*W +: W] = '1;
      end else begin
        out_d[c*W +: W] = s1_sum_q[c][W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      noise_q      <= '0;
      count_q      <= '0;
      blk_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned c = 0; c < C; c++) begin
        mean_q[c]   <= '0;
        var_q[c]    <= '0;
        gain_q[c]   <= '0;
        s1_sum_q[c] <= '0;
      end
    end else begin
      overrun_q <= 1'b0;

      if (latch_stats) begin
        noise_q <= noise_variance;
        for (int unsigned c = 0; c < C; c++) begin
          mean_q[c] <= mean_sat[c];
          var_q[c]  <= variance_of_block[c*SW +: SW];
        end
      end

      case (state_q)
        IDLE: begin
          if (stats_ready) begin
            state_q <= GAIN;
          end
        end
        GAIN: begin
          for (int unsigned c = 0; c < C; c++) begin
            gain_q[c] <= gain_d[c];
          end
          state_q <= STREAM;
          ready_q <= 1'b1;
          if (stats_ready) begin
            overrun_q <= 1'b1;
          end
        end
        STREAM: begin
          if (last_accept) begin
            state_q <= stats_ready ? GAIN : IDLE;
            ready_q <= 1'b0;
          end else if (stats_ready) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase

      if (accept) begin
        count_q <= last_accept ? '0 : count_q + 32'd1;
        for (int unsigned c = 0; c < C; c++) begin
          s1_sum_q[c] <= sum_d[c];
        end
      end
      s1_valid_q <= accept;
      s1_last_q  <= last_accept;

      out_valid_q  <= s1_valid_q;
      block_done_q <= s1_valid_q && s1_last_q;
      frame_done_q <= s1_valid_q && s1_last_q && frame_hit;
      if (s1_valid_q) begin
        out_q <= out_d;
      end
      if (s1_valid_q && s1_last_q) begin
        blk_q <= frame_hit ? '0 : blk_q + 32'd1;
      end
    end
  end

  assign data_in_ready  = ready_q;
  assign data_out       = out_q;
  assign data_out_valid = out_valid_q;
  assign data_count_out = count_q;
  assign block_done     = block_done_q;
  assign frame_done     = frame_done_q;
  assign stats_overrun  = overrun_q;

endmodule

// File: tb/tb_wiener_calc_mc.sv
// Directed self-checking bench for wiener_calc_mc (W=8, C=3, 64 pixels/block).
module tb_wiener_calc_mc;
  localparam int W  = 8;
  localparam int C  = 3;
  localparam int N  = 64;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stats_ready = 1'b0;
  logic [C*SW-1:0] mean_of_block = '0;
  logic [C*SW-1:0] variance_of_block = '0;
  logic [SW-1:0]   noise_variance = '0;
  logic [31:0]     blocks_per_frame = 32'd1;
  logic [C*W-1:0]  data_in = '0;
  logic            data_in_valid = 1'b0;
  logic            data_in_ready;
  logic [C*W-1:0]  data_out;
  logic            data_out_valid;
  logic [31:0]     data_count_out;
  logic            block_done;
  logic            frame_done;
  logic            stats_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wiener_calc_mc #(
    .DATA_WIDTH(W),
    .TOTAL_SAMPLES(N),
    .NUM_CHANNELS(C),
    .GAIN_FRAC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stats_ready(stats_ready),
    .mean_of_block(mean_of_block),
    .variance_of_block(variance_of_block),
    .noise_variance(noise_variance),
    .blocks_per_frame(blocks_per_frame),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_count_out(data_count_out),
    .block_done(block_done),
    .frame_done(frame_done),
    .stats_overrun(stats_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stats_ready = 1'b0;
    data_in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_stats(input logic [SW-1:0] m0, m1, m2, v0, v1, v2, nz);
    mean_of_block     = {m2, m1, m0};
    variance_of_block = {v2, v1, v0};
    noise_variance    = nz;
  endtask

  // IDLE -> GAIN -> STREAM; returns with data_in_ready expected high.
  task automatic load_stats();
    stats_ready = 1'b1;
    step();
    stats_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stats_ready = 1'b1;
    data_in_valid = 1'b1;
    data_in = 24'hC0C0C0;
    step();
    step();
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", data_out_valid); end
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", data_in_ready); end
    total++; if (data_count_out !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", data_count_out); end
    total++; if (block_done !== 1'b0) begin bad++; $display("FAIL reset_block_done: got %b want 0", block_done); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    total++; if (stats_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", stats_overrun); end
    stats_ready = 1'b0;
    data_in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL reset_idle_ready: got %b want 0", data_in_ready); end
  endtask

  // mean 0x80, var 0x40, noise 0x20 -> gain 128; also floor on negatives.
  task automatic test_gain();
    do_reset();
    blocks_per_frame = 32'd1;
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h40, 16'h40, 16'h20);
    load_stats();
    total++; if (data_in_ready !== 1'b1) begin bad++; $display("FAIL gain_ready: got %b want 1", data_in_ready); end
    data_in_valid = 1'b1;
    data_in = 24'hC0C0C0;
    step();
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL gain_latency1: got %b want 0", data_out_valid); end
    data_in = 24'h7FFF00;
    step();
    data_in_valid = 1'b0;
    total++; if (data_out_valid !== 1'b1) begin bad++; $display("FAIL gain_latency2: got %b want 1", data_out_valid); end
    total++; if (data_out !== 24'hA0A0A0) begin bad++; $display("FAIL gain_px1: got %h want a0a0a0", data_out); end
    step();
    total++; if (data_out !== 24'h7FBF40) begin bad++; $display("FAIL gain_px2_floor: got %h want 7fbf40", data_out); end
    total++; if (data_count_out !== 32'd2) begin bad++; $display("FAIL gain_count: got %0d want 2", data_count_out); end
    step();
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL gain_valid_drop: got %b want 0", data_out_valid); end
  endtask

  // Distinct variances: gains 128, 85, 224.
  task automatic test_channels();
    do_reset();
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h30, 16'h100, 16'h20);
    load_stats();
    data_in_valid = 1'b1;
    data_in = 24'hC0C0C0;
    step();
    data_in_valid = 1'b0;
    step();
    total++; if (data_out !== 24'hB895A0) begin bad++; $display("FAIL channels_out: got %h want b895a0", data_out); end
  endtask

  // var <= noise or var = 0 -> gain 0; mean 0x150 saturates to 0xFF.
  task automatic test_zero_gain();
    do_reset();
    set_stats(16'h0150, 16'h0033, 16'h0080, 16'h10, 16'h10, 16'h00, 16'h20);
    load_stats();
    data_in_valid = 1'b1;
    data_in = 24'h563412;
    step();
    data_in_valid = 1'b0;
    step();
    total++; if (data_out !== 24'h8033FF) begin bad++; $display("FAIL zero_gain_out: got %h want 8033ff", data_out); end
  endtask

  task automatic test_stream_gaps();
    int sent = 0, outs = 0, dones = 0, frames = 0, done_idx = -1, badval = 0;
    logic [31:0] maxcnt = 0;
    do_reset();
    blocks_per_frame = 32'd0;
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h40, 16'h40, 16'h20);
    load_stats();
    data_in = 24'hC0C0C0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      data_in_valid = (cyc % 2 == 0);
      if (data_in_valid && data_in_ready) sent++;
      step();
      if (data_out_valid) begin
        outs++;
        if (data_out !== 24'hA0A0A0) badval++;
        if (block_done) done_idx = outs;
      end
      if (block_done) dones++;
      if (frame_done) frames++;
      if (data_count_out > maxcnt) maxcnt = data_count_out;
    end
    data_in_valid = 1'b0;
    total++; if (sent != N) begin bad++; $display("FAIL gaps_accepted: got %0d want %0d", sent, N); end
    total++; if (outs != N) begin bad++; $display("FAIL gaps_outputs: got %0d want %0d", outs, N); end
    total++; if (badval != 0) begin bad++; $display("FAIL gaps_values: got %0d wrong want 0", badval); end
    total++; if (dones != 1) begin bad++; $display("FAIL gaps_block_done: got %0d want 1", dones); end
    total++; if (done_idx != N) begin bad++; $display("FAIL gaps_done_pos: got %0d want %0d", done_idx, N); end
    total++; if (frames != 1) begin bad++; $display("FAIL gaps_frame_bpf0: got %0d want 1", frames); end
    total++; if (maxcnt !== 32'd63) begin bad++; $display("FAIL gaps_count_max: got %0d want 63", maxcnt); end
    total++; if (data_count_out !== 32'd0) begin bad++; $display("FAIL gaps_count_end: got %0d want 0", data_count_out); end
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL gaps_ready_end: got %b want 0", data_in_ready); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, outs = 0, dones = 0, frames = 0, gaps = 0, badval = 0, ovr = 0;
    int done1 = -1, done2 = -1, frame_at = -1;
    logic [C*W-1:0] exp_v;
    do_reset();
    blocks_per_frame = 32'd2;
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h40, 16'h40, 16'h20);
    load_stats();
    data_in = 24'hC0C0C0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      data_in_valid = (sent < 2 * N);
      stats_ready = 1'b0;
      if (sent > 0 && sent < 2 * N && !data_in_ready) gaps++;
      if (sent == N - 1 && data_in_ready) begin
        stats_ready = 1'b1;
        set_stats(16'h33, 16'h33, 16'h33, 16'h10, 16'h10, 16'h10, 16'h20);
      end
      if (data_in_valid && data_in_ready) sent++;
      step();
      if (data_out_valid) begin
        outs++;
        exp_v = (outs <= N) ? 24'hA0A0A0 : 24'h333333;
        if (data_out !== exp_v) badval++;
      end
      if (block_done) begin
        dones++;
        if (dones == 1) done1 = outs; else done2 = outs;
      end
      if (frame_done) begin
        frames++;
        frame_at = outs;
      end
      if (stats_overrun) ovr++;
    end
    stats_ready = 1'b0;
    data_in_valid = 1'b0;
    total++; if (outs != 2 * N) begin bad++; $display("FAIL b2b_outputs: got %0d want %0d", outs, 2 * N); end
    total++; if (gaps != 1) begin bad++; $display("FAIL b2b_ready_gap: got %0d want 1", gaps); end
    total++; if (badval != 0) begin bad++; $display("FAIL b2b_values: got %0d wrong want 0", badval); end
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_block_done: got %0d want 2", dones); end
    total++; if (done1 != N || done2 != 2 * N) begin bad++; $display("FAIL b2b_done_pos: got %0d,%0d want %0d,%0d", done1, done2, N, 2 * N); end
    total++; if (frames != 1 || frame_at != 2 * N) begin bad++; $display("FAIL b2b_frame_done: got %0d at %0d want 1 at %0d", frames, frame_at, 2 * N); end
    total++; if (ovr != 0) begin bad++; $display("FAIL b2b_overrun: got %0d want 0", ovr); end
  endtask

  task automatic test_overrun();
    int outs = 0, badval = 0, ovr = 0;
    do_reset();
    blocks_per_frame = 32'd1;
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h40, 16'h40, 16'h20);
    stats_ready = 1'b1;
    step();
    set_stats(16'h33, 16'h33, 16'h33, 16'h10, 16'h10, 16'h10, 16'h20);
    step();
    stats_ready = 1'b0;
    total++; if (stats_overrun !== 1'b1) begin bad++; $display("FAIL ovr_in_gain: got %b want 1", stats_overrun); end
    total++; if (data_in_ready !== 1'b1) begin bad++; $display("FAIL ovr_gain_ready: got %b want 1", data_in_ready); end
    data_in = 24'hC0C0C0;
    for (int i = 0; i < 14; i++) begin
      data_in_valid = (i < 10);
      stats_ready = (i == 5);
      step();
      if (i == 5) begin
        total++; if (stats_overrun !== 1'b1) begin bad++; $display("FAIL ovr_stream_pulse: got %b want 1", stats_overrun); end
      end
      if (stats_overrun) ovr++;
      if (data_out_valid) begin
        outs++;
        if (data_out !== 24'hA0A0A0) badval++;
      end
    end
    stats_ready = 1'b0;
    data_in_valid = 1'b0;
    total++; if (ovr != 1) begin bad++; $display("FAIL ovr_stream_width: got %0d want 1", ovr); end
    total++; if (outs != 10 || badval != 0) begin bad++; $display("FAIL ovr_outputs: got %0d outs %0d wrong want 10 outs 0 wrong", outs, badval); end
    total++; if (data_count_out !== 32'd10) begin bad++; $display("FAIL ovr_count: got %0d want 10", data_count_out); end
  endtask

  task automatic test_reset_mid();
    int vcnt = 0, dcnt = 0, rcnt = 0;
    do_reset();
    set_stats(16'h80, 16'h80, 16'h80, 16'h40, 16'h40, 16'h40, 16'h20);
    load_stats();
    data_in = 24'hC0C0C0;
    data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (data_out !== '0) begin bad++; $display("FAIL mid_data_out: got %h want 0", data_out); end
    total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", data_out_valid); end
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", data_in_ready); end
    total++; if (data_count_out !== 32'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", data_count_out); end
    total++; if (block_done !== 1'b0 || frame_done !== 1'b0 || stats_overrun !== 1'b0) begin
      bad++; $display("FAIL mid_pulses: got %b%b%b want 000", block_done, frame_done, stats_overrun);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_out_valid) vcnt++;
      if (block_done) dcnt++;
      if (data_in_ready) rcnt++;
    end
    data_in_valid = 1'b0;
    total++; if (vcnt != 0 || dcnt != 0) begin bad++; $display("FAIL mid_no_outputs: got %0d valid %0d done want 0 0", vcnt, dcnt); end
    total++; if (rcnt != 0) begin bad++; $display("FAIL mid_idle: got %0d ready cycles want 0", rcnt); end
  endtask

  initial begin
    test_reset();
    test_gain();
    test_channels();
    test_zero_gain();
    test_stream_gaps();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wiener_calc_mc.md
WIENER_CALC_MC -- requirements
Module: wiener_calc_mc

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, pixel bits per channel (W).
- TOTAL_SAMPLES, 64, pixels per block.
- NUM_CHANNELS, 3, channels processed in lockstep (C).
- GAIN_FRAC, 8, fractional bits of the Wiener gain.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, synchronous, active-low reset.
- stats_ready, in, 1, one-cycle pulse: block statistics are valid.
- mean_of_block, in, C*2W, per-channel mean; channel c at bits [c*2W +: 2W].
- variance_of_block, in, C*2W, per-channel variance.
- noise_variance, in, 2W, noise variance shared by all channels.
- blocks_per_frame, in, 32, number of blocks per frame.
- data_in, in, C*W, pixel of every channel.
- data_in_valid, in, 1, data_in is valid.
- data_in_ready, out, 1, block accepts a pixel.
- data_out, out, C*W, filtered pixel.
- data_out_valid, out, 1, data_out is valid.
- data_count_out, out, 32, pixels accepted in the current block.
- block_done, out, 1, one-cycle pulse with the block's last output.
- frame_done, out, 1, one-cycle pulse with the frame's last output.
- stats_overrun, out, 1, one-cycle pulse: stats_ready arrived while busy, and the stats were dropped.

Function
REQ-003 The FSM SHALL have three states: IDLE, GAIN and STREAM.
- IDLE goes to GAIN on stats_ready.
- GAIN goes to STREAM after exactly 1 cycle.
- STREAM goes to IDLE after the TOTAL_SAMPLES-th accepted pixel.

REQ-004 On stats_ready in IDLE, the block SHALL latch the mean of each channel, saturated to 2^W-1, and the variance of each channel and noise_variance.

REQ-005 In GAIN, each channel gain SHALL be registered as follows.
- gain_c = floor(((var_c - noise) << GAIN_FRAC) / var_c) if var_c > noise.
- gain_c = 0 otherwise, which includes var_c = 0.

REQ-006 data_in_ready SHALL be 1 only in STREAM; a pixel is accepted when data_in_valid and data_in_ready are both 1.

REQ-007 For each accepted pixel and channel, the block SHALL compute the output as follows.
- d = x - m, signed W+1 bits.
- p = (gain_c * d) >>> GAIN_FRAC, an arithmetic shift that rounds toward minus infinity.
- out = clamp(m + p, 0, 2^W-1).

REQ-008 The pipeline SHALL be 2 stages.
- data_out_valid is 1 exactly 2 cycles after each accepted pixel.
- Gaps in data_in_valid are preserved, and the block applies no backpressure to its output.

REQ-009 data_count_out SHALL increment on each accepted pixel and return to 0 on the cycle after the TOTAL_SAMPLES-th accepted pixel.

REQ-010 block_done SHALL be 1 in the same cycle that data_out_valid is 1 for the block's last pixel.

REQ-011 An internal block counter SHALL increment on each block_done.
- frame_done is 1 together with block_done when the counter reaches blocks_per_frame; the counter then returns to 0.
- If blocks_per_frame is 0, it is treated as 1.

REQ-012 If stats_ready arrives in the same cycle as the TOTAL_SAMPLES-th accepted pixel, the block SHALL latch the stats and go to GAIN, not IDLE.
- The previous block's pixels still in the pipeline finish with the old gains and means.

REQ-013 A stats_ready in GAIN, or in STREAM other than the case in REQ-012, SHALL be ignored and SHALL raise stats_overrun for 1 cycle.

REQ-014 All intermediate widths SHALL be sized so that no overflow occurs for any parameter values: the product is 2W+GAIN_FRAC+2 bits signed.

Reset
REQ-015 While rst_n = 0 at a clock edge, the block SHALL clear the following.
- The FSM goes to IDLE.
- data_out, data_count_out and the block counter go to 0.
- data_out_valid, data_in_ready, block_done, frame_done and stats_overrun go to 0.
- Pipeline valid bits and latched stats go to 0.

REQ-016 A reset in mid-block SHALL discard any partial block and any outputs in flight, and SHALL produce no block_done.

Verification
REQ-017 C=3, GAIN_FRAC=8, mean 0x80, var 0x40, noise 0x20, data_in 0xC0 on all channels -> gain 128, data_out 0xA0 on every channel, 2 cycles after the pixel is accepted.

REQ-018 var 0x10, noise 0x20, any x -> data_out = mean (gain 0); mean 0x0150 -> it is saturated, and data_out = 0xFF.

REQ-019 64 pixels with data_in_valid toggling 1010... -> exactly 64 outputs, data_count_out reaches 63 and then 0, and a single block_done with the 64th output.

REQ-020 blocks_per_frame=2, two back-to-back blocks with stats_ready on the last pixel of block 1 -> no gap in data_in_ready beyond the GAIN cycle, block_done twice, and frame_done only on the second.

REQ-021 stats_ready pulsed mid-STREAM -> stats_overrun for 1 cycle, and the gains and outputs are unchanged.

REQ-022 rst_n low for 1 cycle after the 10th pixel -> all outputs 0 the next cycle, FSM in IDLE, and no further data_out_valid.
